// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one memory port with starvation limit and timeout abort
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ready,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ready,
   output logic [DW-1:0] d_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          bus_err,
   output logic          busy
);
   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIM);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
   state_t state, state_nx;
   logic [SW-1:0] streak;
   logic [TW-1:0] wcnt;
   logic in_busy, grant_i, grant_d, abort, finish;
   always_comb begin
      in_busy  = state == BUSY_I || state == BUSY_D;
      grant_i  = state == IDLE && if_req && (!d_req || streak == S_MAX);
      grant_d  = state == IDLE && d_req && !grant_i;
      abort    = !mem_ready && wcnt == T_MAX;
      finish   = in_busy && (mem_ready || abort);
      state_nx = grant_i ? BUSY_I : grant_d ? BUSY_D : finish ? DONE : state == DONE ? IDLE : state;
   end
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         streak    <= '0;
         wcnt      <= '0;
         if_ready  <= 1'b0;
         if_rdata  <= '0;
         d_ready   <= 1'b0;
         d_rdata   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         bus_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if_ready <= finish && state == BUSY_I;
         d_ready  <= finish && state == BUSY_D;
         busy     <= state_nx != IDLE;
         if (state == IDLE)
            streak <= (grant_i || !if_req) ? '0 : (grant_d && streak != S_MAX) ? streak + SW'(1) : streak;
         if (grant_i || grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_d && d_we;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            wcnt      <= '0;
         end
         if (in_busy && !finish) wcnt <= wcnt + TW'(1);
         if (finish) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= bus_err | abort;
            if (state == BUSY_I) if_rdata <= abort ? '0 : mem_rdata;
            else d_rdata <= (abort || mem_we) ? '0 : mem_rdata;
         end
      end
   end
endmodule
